// File: rtl/kuznechik_pkg.sv
// Shared definitions for the Kuznechik (GOST R 34.12-2015) cipher core:
// round count, FSM encoding, L-transform coefficients, forward S-box,
// GF(2^8) multiply and, with KUZNECHIK_DECRYPT_EN, the inverse S-box.
package kuznechik_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_SUB,
        ST_LIN,
        ST_DONE
    } state_t;

    typedef logic [7:0] byte_tab_t [256];

    // Coefficient k multiplies byte b[15-k] of the LFSR state
    localparam logic [7:0] L_COEF [16] = '{
        8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
        8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
    };

    // Forward substitution pi
    localparam byte_tab_t SBOX = '{
        8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
        8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
        8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
        8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
        8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
        8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
        8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
        8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
        8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
        8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
        8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
        8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
        8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
        8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
        8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
        8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
    };

    // Multiply in GF(2^8) modulo x^8+x^7+x^6+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

`ifdef KUZNECHIK_DECRYPT_EN
    // Inverse table derived from pi at elaboration so the two cannot drift apart
    function automatic byte_tab_t invert_tab(input byte_tab_t t);
        byte_tab_t r;
        for (int i = 0; i < 256; i++) r[t[i]] = 8'(i);
        return r;
    endfunction

    localparam byte_tab_t SBOX_INV = invert_tab(SBOX);
`endif

endpackage

// File: rtl/kuznechik_l_step.sv
// One step of the Kuznechik L-transform LFSR (R, or R^-1 when inv=1).
// Purely combinational; chained L_STEPS deep in the cipher core.
// The inverse path is only built with KUZNECHIK_DECRYPT_EN.
module kuznechik_l_step
    import kuznechik_pkg::*;
(
    input  logic         inv,
    input  logic [127:0] d,
    output logic [127:0] q
);

    logic [7:0] fwd_fb;

    // Forward feedback byte: coefficient k weights byte 15-k
    always_comb begin
        fwd_fb = '0;
        for (int k = 0; k < 16; k++) fwd_fb = fwd_fb ^ gf_mul(L_COEF[k], d[8*(15-k) +: 8]);
    end

`ifdef KUZNECHIK_DECRYPT_EN
    logic [7:0] inv_fb;

    // Inverse feedback: same coefficients over (b14..b0, b15)
    always_comb begin
        inv_fb = gf_mul(L_COEF[15], d[127:120]);
        for (int k = 0; k < 15; k++) inv_fb = inv_fb ^ gf_mul(L_COEF[k], d[8*(14-k) +: 8]);
    end

    assign q = inv ? {d[119:0], inv_fb} : {fwd_fb, d[127:8]};
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign q = {fwd_fb, d[127:8]};
`endif

endmodule

// File: rtl/kuznechik_cipher_xp.sv
// Kuznechik 128-bit block cipher core, one block in flight.
// L_STEPS LFSR steps are folded into each LIN cycle (legal 1,2,4,8,16).
// Round keys live in a 10-entry register file written through the key port;
// the file-name parameters are kept so existing instantiations still elaborate,
// the S-boxes come from constants in kuznechik_pkg and the key file powers up
// undefined until written.
// Optional: define KUZNECHIK_DECRYPT_EN to honour decrypt_i and build the
// inverse S-box and L^-1 datapath.
module kuznechik_cipher_xp
    import kuznechik_pkg::*;
#(
    parameter int L_STEPS       = 1,
    parameter     KEY_INIT_FILE = "keys.mem",
    parameter     SBOX_FILE     = "S_box.mem"
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         request_i,
    input  logic         decrypt_i,
    input  logic [127:0] data_i,
    input  logic         ack_i,
    input  logic         key_we_i,
    input  logic [3:0]   key_addr_i,
    input  logic [127:0] key_data_i,
    output logic         busy_o,
    output logic         valid_o,
    output logic [127:0] data_o
);

    localparam int         LIN_CYCLES = 16 / L_STEPS;
    localparam logic [3:0] LAST_STEP  = 4'(LIN_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam int         unused_file_param_bits = $bits(KEY_INIT_FILE) + $bits(SBOX_FILE);

    generate
        if (L_STEPS != 1 && L_STEPS != 2 && L_STEPS != 4 && L_STEPS != 8 && L_STEPS != 16) begin : g_bad_l_steps
            $error("kuznechik_cipher_xp: L_STEPS must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t                    state;
    logic [127:0]              blk;
    logic [3:0]                rnd;
    logic [3:0]                step;
    logic                      dec;
    logic                      mode_in;
    logic                      accept;
    logic [127:0]              key_mem [NUM_ROUNDS];
    logic [3:0]                key_idx;
    logic [127:0]              rkey;
    logic [127:0]              sub_out;
    logic [127:0]              lin_out;
    logic [L_STEPS:0][127:0]   chain;

`ifdef KUZNECHIK_DECRYPT_EN
    assign mode_in = decrypt_i;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt_i;
    assign mode_in        = 1'b0;
`endif

    assign busy_o = (state == ST_KEY) || (state == ST_SUB) || (state == ST_LIN);
    assign accept = request_i && (state == ST_IDLE || state == ST_DONE);

    // Round-key file: only writable while idle/done, out-of-range addresses dropped
    always_ff @(posedge clk_i) begin
        if (key_we_i && !busy_o && key_addr_i <= LAST_ROUND)
            key_mem[key_addr_i] <= key_data_i;
    end

    // Decryption walks the key schedule backwards
    assign key_idx = dec ? (LAST_ROUND - rnd) : rnd;
    assign rkey    = key_mem[key_idx];

    // 16 parallel S-box lookups
    for (genvar i = 0; i < 16; i++) begin : g_sbox
`ifdef KUZNECHIK_DECRYPT_EN
        assign sub_out[8*i +: 8] = dec ? SBOX_INV[blk[8*i +: 8]] : SBOX[blk[8*i +: 8]];
`else
        assign sub_out[8*i +: 8] = SBOX[blk[8*i +: 8]];
`endif
    end

    // L_STEPS LFSR steps per LIN cycle
    assign chain[0] = blk;
    for (genvar s = 0; s < L_STEPS; s++) begin : g_lstep
        kuznechik_l_step u_step (
            .inv (dec),
            .d   (chain[s]),
            .q   (chain[s+1])
        );
    end
    assign lin_out = chain[L_STEPS];

    // Round sequencer: KEY -> SUB -> LIN (encrypt) or KEY -> LIN^-1 -> SUB^-1 (decrypt)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
            data_o  <= '0;
            rnd     <= '0;
            step    <= '0;
            blk     <= '0;
            dec     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        blk     <= data_i;
                        dec     <= mode_in;
                        rnd     <= '0;
                        step    <= '0;
                        valid_o <= 1'b0;
                        state   <= ST_KEY;
                    end else if (state == ST_DONE && ack_i) begin
                        valid_o <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_KEY: begin
                    blk <= blk ^ rkey;
                    if (rnd == LAST_ROUND) begin
                        data_o  <= blk ^ rkey;
                        valid_o <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        state <= dec ? ST_LIN : ST_SUB;
                    end
                end
                ST_SUB: begin
                    blk <= sub_out;
                    if (dec) begin
                        rnd   <= rnd + 4'd1;
                        state <= ST_KEY;
                    end else begin
                        state <= ST_LIN;
                    end
                end
                ST_LIN: begin
                    blk <= lin_out;
                    if (step == LAST_STEP) begin
                        step <= '0;
                        if (dec) begin
                            state <= ST_SUB;
                        end else begin
                            rnd   <= rnd + 4'd1;
                            state <= ST_KEY;
                        end
                    end else begin
                        step <= step + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kuznechik_cipher_xp.sv
// Directed bench for kuznechik_cipher_xp using the GOST R 34.12-2015
// reference key schedule and plaintext/ciphertext pair.
module tb_kuznechik_cipher_xp;

    localparam int L_STEPS = 1;
    localparam int LAT     = 9 * (2 + 16 / L_STEPS) + 1;

    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

    localparam logic [127:0] RK [10] = '{
        128'h8899aabbccddeeff0011223344556677,
        128'hfedcba98765432100123456789abcdef,
        128'hdb31485315694343228d6aef8cc78c44,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'h57646468c44a5e28d3e59246f429f1ac,
        128'hbd079435165c6432b532e82834da581b,
        128'h51e640757e8745de705727265a0098b1,
        128'h5a7925017b9fdd3ed72a91a22286f984,
        128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h72e9dd7416bcf45b755dbaa88e4a4043
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         request;
    logic         decrypt;
    logic [127:0] data_in;
    logic         ack;
    logic         key_we;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic         busy;
    logic         valid;
    logic [127:0] data_out;

    logic         ls_inv;
    logic [127:0] ls_d;
    logic [127:0] ls_q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    kuznechik_cipher_xp #(.L_STEPS(L_STEPS)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .request_i  (request),
        .decrypt_i  (decrypt),
        .data_i     (data_in),
        .ack_i      (ack),
        .key_we_i   (key_we),
        .key_addr_i (key_addr),
        .key_data_i (key_data),
        .busy_o     (busy),
        .valid_o    (valid),
        .data_o     (data_out)
    );

    kuznechik_l_step u_lstep (
        .inv (ls_inv),
        .d   (ls_d),
        .q   (ls_q)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic key_write(input logic [3:0] addr, input logic [127:0] val);
        @(negedge clk);
        key_we   = 1'b1;
        key_addr = addr;
        key_data = val;
        @(negedge clk);
        key_we   = 1'b0;
    endtask

    // Present a block at the negedge; returns #1 after the acceptance edge
    task automatic accept_block(input logic [127:0] din, input logic dec, input logic with_ack);
        @(negedge clk);
        request = 1'b1;
        data_in = din;
        decrypt = dec;
        ack     = with_ack;
        @(posedge clk);
        #1;
        request = 1'b0;
        decrypt = 1'b0;
        ack     = 1'b0;
        data_in = '0;
    endtask

    // Count edges until valid; ev: 1=request while busy, 2=key write while busy, 3=reset pulse
    task automatic wait_result(input int ev_at, input int ev, input string tag,
                               output logic [127:0] dout, output int lat);
        logic [127:0] prev;
        prev = data_out;
        lat  = 0;
        dout = '0;
        while (!valid && lat < 400) begin
            if (lat == ev_at) begin
                case (ev)
                    1: begin request = 1'b1; data_in = ~PT; end
                    2: begin key_we = 1'b1; key_addr = 4'd0; key_data = '0; end
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            @(posedge clk);
            #1;
            lat++;
            request = 1'b0;
            key_we  = 1'b0;
            if (lat == 1) begin
                check({tag, "_busy"}, 128'(busy), 128'd1);
                check({tag, "_no_partial"}, data_out, prev);
            end
            if (ev == 3 && lat == ev_at + 1) begin
                rst = 1'b0;
                check({tag, "_rst_valid"}, 128'(valid), 128'd0);
                check({tag, "_rst_data"}, data_out, 128'd0);
                check({tag, "_rst_busy"}, 128'(busy), 128'd0);
                return;
            end
        end
        dout = data_out;
    endtask

    initial begin
        logic [127:0] res;
        int           lat;

        rst      = 1'b1;
        request  = 1'b0;
        decrypt  = 1'b0;
        data_in  = '0;
        ack      = 1'b0;
        key_we   = 1'b0;
        key_addr = '0;
        key_data = '0;
        ls_inv   = 1'b0;
        ls_d     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 128'(valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_data", data_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single R / R^-1 steps from the standard's examples
        ls_inv = 1'b0; ls_d = 128'h00000000000000000000000000000100; #1;
        check("r_step_1", ls_q, 128'h94000000000000000000000000000001);
        ls_d = 128'h94000000000000000000000000000001; #1;
        check("r_step_2", ls_q, 128'ha5940000000000000000000000000000);
`ifdef KUZNECHIK_DECRYPT_EN
        ls_inv = 1'b1; ls_d = 128'ha5940000000000000000000000000000; #1;
        check("rinv_step_1", ls_q, 128'h94000000000000000000000000000001);
        ls_d = 128'h94000000000000000000000000000001; #1;
        check("rinv_step_2", ls_q, 128'h00000000000000000000000000000100);
`endif

        for (int i = 0; i < 10; i++) key_write(4'(i), RK[i]);
        key_write(4'd12, {128{1'b1}});

        // Reference encryption (also shows the addr-12 write had no effect)
        accept_block(PT, 1'b0, 1'b0);
        wait_result(-1, 0, "enc", res, lat);
        check("enc_latency", 128'(lat), 128'(LAT));
        check("enc_result", res, CT);

        // DONE holds its result
        repeat (5) @(posedge clk);
        #1;
        check("done_valid_hold", 128'(valid), 128'd1);
        check("done_data_hold", data_out, CT);
        check("done_not_busy", 128'(busy), 128'd0);

        // New request in DONE with ack: restarts, ack ignored
        accept_block(PT, 1'b0, 1'b1);
        check("restart_valid_low", 128'(valid), 128'd0);
        check("restart_data_kept", data_out, CT);
        wait_result(-1, 0, "restart", res, lat);
        check("restart_latency", 128'(lat), 128'(LAT));
        check("restart_result", res, CT);

        // Ack returns to IDLE, data_o untouched
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("ack_valid_low", 128'(valid), 128'd0);
        check("ack_not_busy", 128'(busy), 128'd0);
        check("ack_data_kept", data_out, CT);

        // Request while busy is dropped
        accept_block(PT, 1'b0, 1'b0);
        wait_result(10, 1, "busy_req", res, lat);
        check("busy_req_latency", 128'(lat), 128'(LAT));
        check("busy_req_result", res, CT);

        // Key write while busy is dropped
        accept_block(PT, 1'b0, 1'b0);
        wait_result(20, 2, "busy_key", res, lat);
        check("busy_key_result", res, CT);

        // Key write when not busy takes effect
        key_write(4'd0, '0);
        accept_block(PT, 1'b0, 1'b0);
        wait_result(-1, 0, "idle_key", res, lat);
        check("idle_key_differs", 128'(res != CT), 128'd1);
        key_write(4'd0, RK[0]);

        // Reset mid-block aborts, keys survive
        accept_block(PT, 1'b0, 1'b0);
        wait_result(50, 3, "midrst", res, lat);
        accept_block(PT, 1'b0, 1'b0);
        wait_result(-1, 0, "after_rst", res, lat);
        check("after_rst_latency", 128'(lat), 128'(LAT));
        check("after_rst_result", res, CT);

`ifdef KUZNECHIK_DECRYPT_EN
        accept_block(CT, 1'b1, 1'b0);
        wait_result(-1, 0, "dec", res, lat);
        check("dec_latency", 128'(lat), 128'(LAT));
        check("dec_result", res, PT);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
